// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered WIDTH-bit ALU with a start/done handshake.
//
// Operands and opcode are latched when a request is accepted, the result and
// flags are computed from the latched copies, and F/OF/ZF are registered and
// only change in the cycle that done pulses.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : opcode 1000 is an unsigned shift-add multiply, one multiplier
//               bit per EXEC cycle (WIDTH EXEC cycles).
//   undefined : opcode 1000 is treated like any other undefined code; no
//               counter or accumulator exists.
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0
// (state IDLE or DONE). While busy=1 start is ignored and nothing is queued.
// done is a one-cycle pulse marking the cycle in which F/OF/ZF were updated.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset (aborts any operation)
//   start        in   request, sampled only while busy=0
//   ALU_OP[3:0]  in   operation code, latched on accept
//   A, B         in   operands (WIDTH bits), latched on accept
//   busy         out  operation in progress
//   done         out  one-cycle pulse, result registers updated this cycle
//   F            out  registered result (WIDTH bits)
//   OF           out  registered overflow flag
//   ZF           out  registered zero flag
//   o_dbg_state  out  current FSM state (0 IDLE, 1 EXEC, 2 DONE)
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             OF,
  output logic             ZF,
  output logic [1:0]       o_dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Single-cycle datapath, driven only by the latched operands.
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu_f;
  logic             w_alu_of;

  // Value written to F/OF on the final EXEC cycle, and "this is the final
  // EXEC cycle" (always true for single-cycle ops).
  logic [WIDTH-1:0] w_res_f;
  logic             w_res_of;
  logic             w_last;

  assign w_sum   = r_a + r_b;
  assign w_diff  = r_a - r_b;
  assign w_shamt = r_a[SHW-1:0];

  always_comb begin
    w_alu_f  = '0;
    w_alu_of = 1'b0;
    case (r_op)
      OP_AND: w_alu_f = r_a & r_b;
      OP_OR:  w_alu_f = r_a | r_b;
      OP_XOR: w_alu_f = r_a ^ r_b;
      OP_NOR: w_alu_f = ~(r_a | r_b);
      OP_ADD: begin
        w_alu_f  = w_sum;
        // Overflow: both operands share a sign the result does not.
        w_alu_of = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_f  = w_diff;
        // Overflow: operand signs differ and result sign differs from A.
        w_alu_of = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SLT: w_alu_f = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLL: w_alu_f = r_b << w_shamt;
      // Undefined codes (including 1000 without the multiplier): F=0, OF=0.
      default: begin
        w_alu_f  = '0;
        w_alu_of = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'b1000;
  localparam logic [SHW-1:0] CNT_LOAD = SHW'(WIDTH - 1);

  // Accumulator layout: high half holds the running partial product, low
  // half starts as the multiplier B and is shifted out LSB-first. After
  // WIDTH steps the whole register holds the 2*WIDTH-bit product.
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     w_hi_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_hi_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_acc_nxt = {w_hi_sum, r_acc[WIDTH-1:1]};

  always_comb begin
    w_res_f  = w_alu_f;
    w_res_of = w_alu_of;
    w_last   = 1'b1;
    if (r_op == OP_MUL) begin
      w_res_f  = w_acc_nxt[WIDTH-1:0];
      w_res_of = |w_acc_nxt[2*WIDTH-1:WIDTH];
      w_last   = (r_cnt == '0);
    end
  end
`else
  always_comb begin
    w_res_f  = w_alu_f;
    w_res_of = w_alu_of;
    w_last   = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      F       <= '0;
      OF      <= 1'b0;
      ZF      <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_cnt   <= '0;
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        // IDLE and DONE both accept a new request; DONE accepting is what
        // gives back-to-back operation at one op per two cycles.
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= ALU_OP;
            r_a     <= A;
            r_b     <= B;
`ifdef ALU_SEQ_MUL_EN
            r_cnt   <= CNT_LOAD;
            r_acc   <= {{WIDTH{1'b0}}, B};
`endif
            busy    <= 1'b1;
            r_state <= S_EXEC;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_nxt;
            if (!w_last) begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
`endif
          if (w_last) begin
            F       <= w_res_f;
            OF      <= w_res_of;
            ZF      <= (w_res_f == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32).
// Driver tasks issue requests and push the expected {done cycle, F, OF, ZF}
// into exp_q; a negedge monitor pops on every done and otherwise checks that
// F/OF/ZF hold their last values. The expected values come from a plain
// arithmetic model of the opcode table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W  = 32;
  localparam int EW = 32 + W + 2;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   ALU_OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] F;
  logic         OF;
  logic         ZF;
  logic [1:0]   dbg_state;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ALU_OP      (ALU_OP),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .F           (F),
    .OF          (OF),
    .ZF          (ZF),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  hold_f  = '0;
  logic          hold_of = 1'b0;
  logic          hold_zf = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint       sa;
    longint       sb;
    longint       r;
    logic [W-1:0] f;
    logic         of;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    f  = '0;
    of = 1'b0;
    r  = 0;
    p  = '0;
    case (op)
      4'd0: f = a & b;
      4'd1: f = a | b;
      4'd2: f = a ^ b;
      4'd3: f = ~(a | b);
      4'd4: begin r = sa + sb; f = r[W-1:0]; of = (r > MAXS) || (r < MINS); end
      4'd5: begin r = sa - sb; f = r[W-1:0]; of = (r > MAXS) || (r < MINS); end
      4'd6: f = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: f = b << (a % W);
`ifdef ALU_SEQ_MUL_EN
      4'd8: begin p = {32'd0, a} * {32'd0, b}; f = p[W-1:0]; of = (p[2*W-1:W] != 0); end
`endif
      default: begin f = '0; of = 1'b0; end
    endcase
    return {f, of, (f == '0)};
  endfunction

  function automatic int latency(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
    if (op == 4'd8) return W + 1;
`endif
    return 2;
  endfunction

  // ---------------- driver ----------------
  // Called away from clock edges. Waits for busy=0, presents one request for
  // one edge, then scrambles the inputs so any late sampling is visible.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    while (busy) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        check("busy_timeout", 64'd1, 64'd0);
        return;
      end
    end
    ALU_OP = op; A = a; B = b; start = 1'b1;
    exp_q.push_back({32'(cyc + latency(op)), model(op, a, b)});
    @(posedge clk); #1;
    start  = 1'b0;
    ALU_OP = 4'($urandom_range(0, 15));
    A      = $urandom;
    B      = $urandom;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e[EW-1:W+2]));
          check("F",  64'(F),  64'(e[W+1:2]));
          check("OF", 64'(OF), 64'(e[1]));
          check("ZF", 64'(ZF), 64'(e[0]));
          hold_f  = e[W+1:2];
          hold_of = e[1];
          hold_zf = e[0];
        end
      end else begin
        check("hold_F", 64'(F), 64'(hold_f));
        check("hold_flags", 64'({OF, ZF}), 64'({hold_of, hold_zf}));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n  = 1'b0;
    start  = 1'b0;
    ALU_OP = '0;
    A      = '0;
    B      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_F",    64'(F),    64'd0);
    check("reset_OF",   64'(OF),   64'd0);
    check("reset_ZF",   64'(ZF),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the opcode table.
    issue(4'd4, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'd5, 32'd5, 32'd5);
    issue(4'd3, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'd4, 32'd1);
    issue(4'd7, 32'h24, 32'd1);
    issue(4'd5, 32'h8000_0000, 32'd1);
    issue(4'd8, 32'h0001_0000, 32'h0001_0000);
    issue(4'd8, 32'd3, 32'd7);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(posedge clk);
    #1;

    // start held through EXEC with changing inputs: exactly one done,
    // computed from the operands present at accept.
    ALU_OP = 4'd4; A = 32'd7; B = 32'd8; start = 1'b1;
    exp_q.push_back({32'(cyc + 2), model(4'd4, 32'd7, 32'd8)});
    @(posedge clk); #1;
    check("busy_held_start", 64'(busy), 64'd1);
    ALU_OP = 4'd0; A = 32'd100; B = 32'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Randomized stream, mixing back-to-back requests and idle gaps.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      issue(op, rand_operand(), rand_operand());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Drain before the reset-abort test.
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_before_abort", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of an operation.
`ifdef ALU_SEQ_MUL_EN
    issue(4'd8, 32'h0001_2345, 32'h0000_0777);
    repeat (9) @(posedge clk);
`else
    issue(4'd4, 32'd11, 32'd22);
`endif
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_F",    64'(F),    64'd0);
    check("abort_OF",   64'(OF),   64'd0);
    check("abort_ZF",   64'(ZF),   64'd0);
    exp_q.delete();
    hold_f  = '0;
    hold_of = 1'b0;
    hold_zf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(4'd4, 32'd2, 32'd3);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("final_drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
